sample_delay_ram: RTL and testbench

//  Run-time programmable sample delay line for the audio front end.

---
 rtl/sample_delay_ram.sv | 128 ++++++++++++
 tb/tb_sample_delay_ram.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sample_delay_ram.sv
// rtl/sample_delay_ram.sv - RAM circular-buffer sample delay line, optional dry/wet mix with SDR_MIX_EN
module sample_delay_ram #(
    parameter int DATA_W        = 16,
    parameter int MAX_DEPTH     = 5000,
    parameter int ADDR_W        = 13,
    parameter int DLY_W         = 13,
    parameter int DEFAULT_DELAY = 5000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    input  logic [DLY_W-1:0]  delay_sel,
    input  logic              delay_load,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
`ifdef SDR_MIX_EN
    output logic [DATA_W-1:0] mix_out,
`endif
    output logic              primed
);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int CW = ((ADDR_W > DLY_W) ? ADDR_W : DLY_W) + 1;

    logic [DATA_W-1:0] mem [MAX_DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic [DLY_W-1:0]  fill_cnt;
    logic [DLY_W-1:0]  delay_reg;
    logic [0:0]        state;

    logic [DLY_W-1:0]  delay_sel_c;
    logic [DLY_W-1:0]  delay_eff;
    logic [DLY_W-1:0]  fill_eff;
    logic [DLY_W-1:0]  fill_new;
    logic [0:0]        state_eff;
    logic [CW-1:0]     wr_ext;
    logic [CW-1:0]     dly_ext;
    logic [CW-1:0]     diff;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_ptr_next;
    logic [DATA_W-1:0] out_next;
    logic              force_zero;

    // A load in the same cycle as a sample takes effect before that sample is handled
    always_comb begin
        delay_sel_c = delay_sel;
        if (delay_sel == '0)
            delay_sel_c = DLY_W'(1);
        else if (delay_sel > DLY_W'(MAX_DEPTH))
            delay_sel_c = DLY_W'(MAX_DEPTH);

        delay_eff  = delay_load ? delay_sel_c : delay_reg;
        fill_eff   = delay_load ? '0 : fill_cnt;
        state_eff  = delay_load ? FILL : state;
        force_zero = (state_eff == FILL);
        fill_new   = (fill_eff < delay_eff) ? fill_eff + DLY_W'(1) : fill_eff;

        wr_ext  = CW'(wr_ptr);
        dly_ext = CW'(delay_eff);
        if (wr_ext >= dly_ext)
            diff = wr_ext - dly_ext;
        else
            diff = wr_ext + CW'(MAX_DEPTH) - dly_ext;
        rd_addr = ADDR_W'(diff);

        wr_ptr_next = (wr_ptr == ADDR_W'(MAX_DEPTH - 1)) ? '0 : wr_ptr + ADDR_W'(1);
        out_next    = force_zero ? '0 : mem[rd_addr];
    end

    // Sample buffer write; the read above sees the old word when rd_addr == wr_ptr
    always_ff @(posedge clock) begin
        if (!reset && in_valid)
            mem[wr_ptr] <= data_in;
    end

    // Pointer, fill tracking, FSM and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            delay_reg <= DLY_W'(DEFAULT_DELAY);
            state     <= FILL;
            data_out  <= '0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            delay_reg <= delay_eff;
            if (delay_load) begin
                fill_cnt <= '0;
                state    <= FILL;
                primed   <= 1'b0;
            end
            if (in_valid) begin
                wr_ptr   <= wr_ptr_next;
                fill_cnt <= fill_new;
                state    <= (fill_new == delay_eff) ? RUN : FILL;
                data_out <= out_next;
                primed   <= !force_zero;
            end
        end
    end

`ifdef SDR_MIX_EN
    logic [DATA_W:0]   mix_sum;
    logic [DATA_W-1:0] mix_sat;

    // Dry + delayed sum at one extra bit, clipped to the signed sample range
    always_comb begin
        mix_sum = {data_in[DATA_W-1], data_in} + {out_next[DATA_W-1], out_next};
        mix_sat = mix_sum[DATA_W-1:0];
        if (mix_sum[DATA_W] != mix_sum[DATA_W-1])
            mix_sat = mix_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end

    // Mix output updates alongside data_out
    always_ff @(posedge clock) begin
        if (reset)
            mix_out <= '0;
        else if (in_valid)
            mix_out <= mix_sat;
    end
`endif

endmodule

// File: tb/tb_sample_delay_ram.sv
// tb/tb_sample_delay_ram.sv - directed-vector bench for sample_delay_ram
module tb_sample_delay_ram;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        in_valid;
    logic [12:0] delay_sel;
    logic        delay_load;
    logic [15:0] data_out;
    logic        out_valid;
    logic        primed;
`ifdef SDR_MIX_EN
    logic [15:0] mix_out;
`endif

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clock = ~clock;

    sample_delay_ram dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .delay_sel  (delay_sel),
        .delay_load (delay_load),
        .data_out   (data_out),
        .out_valid  (out_valid),
`ifdef SDR_MIX_EN
        .mix_out    (mix_out),
`endif
        .primed     (primed)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load(input logic [12:0] d);
        delay_sel  = d;
        delay_load = 1'b1;
        @(posedge clock);
        #1;
        delay_load = 1'b0;
        delay_sel  = 13'h1abc;
    endtask

    task automatic send(input logic [15:0] s);
        data_in  = s;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        data_in  = 16'hdead;
    endtask

    task automatic send_chk(input string tag, input logic [15:0] s, input logic [15:0] exp);
        send(s);
        check_vec({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check_vec({tag, " data"}, 32'(data_out), 32'(exp));
    endtask

    int ramp_bad;

    initial begin
        reset = 1'b1; data_in = '0; in_valid = 1'b0; delay_sel = '0; delay_load = 1'b0;
        idle(3);
        reset = 1'b0;
        check_vec("rst data_out", 32'(data_out), 32'd0);
        check_vec("rst out_valid", 32'(out_valid), 32'd0);
        check_vec("rst primed", 32'(primed), 32'd0);

        // 1: D=4, ramp 1..8
        load(13'd4);
        for (int k = 1; k <= 8; k++) begin
            send_chk("t1", 16'(k), (k > 4) ? 16'(k - 4) : 16'd0);
            check_vec("t1 primed", 32'(primed), (k >= 5) ? 32'd1 : 32'd0);
        end
        idle(1);
        check_vec("t1 no strobe", 32'(out_valid), 32'd0);
        check_vec("t1 hold", 32'(data_out), 32'd4);

        // 3: D=0 clamps to 1
        load(13'd0);
        send_chk("t3 d0 a", 16'd10, 16'd0);
        send_chk("t3 d0 b", 16'd20, 16'd10);
        send_chk("t3 d0 c", 16'd30, 16'd20);

        // 2 (+3): D=6000 clamps to 5000, wrap and read-before-write
        load(13'd6000);
        ramp_bad = 0;
        for (int n = 1; n <= 10010; n++) begin
            send(16'(n));
            if (out_valid !== 1'b1 || data_out !== ((n > 5000) ? 16'(n - 5000) : 16'd0))
                ramp_bad++;
            if (n == 5000 || n == 5001 || n == 10010)
                check_vec($sformatf("t2 n=%0d", n), 32'(data_out), (n > 5000) ? 32'(n - 5000) : 32'd0);
        end
        check_vec("t2 ramp errors", 32'(ramp_bad), 32'd0);

        // 4: D=3 in RUN, then load D=2 with a sample
        load(13'd3);
        for (int k = 1; k <= 6; k++)
            send_chk("t4 pre", 16'(k), (k > 3) ? 16'(k - 3) : 16'd0);
        delay_sel  = 13'd2;
        delay_load = 1'b1;
        send(16'd7);
        delay_load = 1'b0;
        check_vec("t4 load+smp", 32'(data_out), 32'd0);
        check_vec("t4 load primed", 32'(primed), 32'd0);
        send_chk("t4 s8", 16'd8, 16'd0);
        send_chk("t4 s9", 16'd9, 16'd7);
        send_chk("t4 s10", 16'd10, 16'd8);

        // 5: sparse strobes, D=3
        load(13'd3);
        for (int k = 0; k < 6; k++) begin
            int stray;
            send_chk("t5", 16'(100 + k), (k >= 3) ? 16'(97 + k) : 16'd0);
            stray = 0;
            for (int c = 0; c < 1041; c++) begin
                @(posedge clock);
                #1;
                if (out_valid) stray++;
            end
            check_vec("t5 gap out_valid", 32'(stray), 32'd0);
            check_vec("t5 gap hold", 32'(data_out), (k >= 3) ? 32'(97 + k) : 32'd0);
        end

        // 6: reset mid-stream wins over load and sample
        load(13'd2);
        for (int k = 1; k <= 4; k++) send(16'(k));
        reset = 1'b1; delay_load = 1'b1; delay_sel = 13'd1; in_valid = 1'b1; data_in = 16'h55;
        @(posedge clock);
        #1;
        reset = 1'b0; delay_load = 1'b0; in_valid = 1'b0;
        check_vec("t6 data_out", 32'(data_out), 32'd0);
        check_vec("t6 out_valid", 32'(out_valid), 32'd0);
        check_vec("t6 primed", 32'(primed), 32'd0);
        ramp_bad = 0;
        for (int n = 1; n <= 5000; n++) begin
            send(16'(n + 1000));
            if (data_out !== 16'd0 || primed !== 1'b0) ramp_bad++;
        end
        check_vec("t6 refill zero", 32'(ramp_bad), 32'd0);
        send_chk("t6 default lag", 16'd7, 16'd1001);
        check_vec("t6 primed", 32'(primed), 32'd1);

`ifdef SDR_MIX_EN
        // 7: saturating mix, D=1
        load(13'd1);
        send(16'h7000);
        check_vec("t7 fill mix", 32'(mix_out), 32'h7000);
        send(16'h7000);
        check_vec("t7 pos sat", 32'(mix_out), 32'h7fff);
        send(16'h9000);
        check_vec("t7 zero", 32'(mix_out), 32'h0000);
        send(16'h9000);
        check_vec("t7 neg sat", 32'(mix_out), 32'h8000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
